rob_commit_ctrl: RTL and testbench
==================================

Name: rob_commit_ctrl

Overview:
- In-order retire side of the re-order buffer; the counterpart to queue-time ROB allocation, which sets valid bits and advances the tail.
- Each cycle, walks from the ROB head and retires up to RSLOTS completed entries.
- Emits a registered clear mask for the ROB valid bits and advances the head.
- An exception at the retire point triggers a flush/redirect handshake.

Parameters:
RENTRIES, 16, number of ROB entries (≥4; index wrap is modulo RENTRIES).
RSLOTS, 2, maximum retirements per cycle (1..4).
RBW, 4, ROB index width; must satisfy 2**RBW ≥ RENTRIES.

Ports:
clk  input  1  clock.
rst  input  1  reset.
rob_v_i  input  RENTRIES  per-entry valid bits (allocated).
rob_done_i  input  RENTRIES  per-entry result complete.
rob_exc_i  input  RENTRIES  per-entry exception flag; meaningful only when done.
commit_stall_i  input  1  downstream (store buffer / regfile) cannot accept a retire this cycle.
redirect_ack_i  input  1  fetch has taken the exception redirect.
rob_head_o  output  RBW  current head index (registered).
rob_clr_o  output  RENTRIES  valid-bit clear mask (registered).
commit_v_o  output  RSLOTS  per-slot retire valid (registered).
commit_rid_o  output  RSLOTS*RBW  packed ROB index per slot; slot k occupies bits [k*RBW +: RBW].
commit_cnt_o  output  3  number of entries retired (registered).
exc_o  output  1  one-cycle exception pulse (registered).
exc_rid_o  output  RBW  ROB index of the excepting entry (held until next exception).
flush_o  output  1  high for exactly the FLUSH cycle; tells the allocator to set its tail to rob_head_o.

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the single clock. All outputs and state go to 0; state = RUN.
- Reset asserted mid-operation aborts any flush immediately.
- States:
  - RUN → FLUSH when an exception is recognised.
  - FLUSH → WAIT unconditionally after one cycle.
  - WAIT → RUN on the first cycle redirect_ack_i=1.
- RUN scan (combinational, from the registered head): for k=0..RSLOTS-1, idx_k=(head+k)%RENTRIES.
  - Slot k retires iff slots 0..k-1 retired, rob_v_i[idx_k]=1, rob_done_i[idx_k]=1 and rob_exc_i[idx_k]=0.
  - The scan stops at the first non-retiring slot.
  - Exception recognised iff the first non-retiring slot j has v=1, done=1, exc=1.
  - If commit_stall_i=1: no retire and no exception recognition that cycle.
- RUN clock edge, for n retired:
  - commit_v_o[k]=1 for k<n; commit_rid_o slot k = idx_k; commit_cnt_o=n.
  - rob_clr_o has bits idx_0..idx_{n-1} set.
  - head <= (head+n)%RENTRIES.
  - Retire outputs are 1-cycle registered pulses, cleared the next cycle when nothing retires.
- Exception recognised: exc_o=1 for one cycle; exc_rid_o = idx_j.
  - Head ends on idx_j; the excepting entry is not retired.
  - Older slots before j retire in the same cycle.
- FLUSH cycle: flush_o=1, rob_clr_o=all ones, commit_v_o=0, head unchanged (points at the excepting entry).
- WAIT: no retire; all rob_clr_o, commit_v_o, exc_o, flush_o=0.
- Boundaries:
  - Empty ROB (rob_v_i[head]=0) → 0 retired, head holds.
  - Entry valid but not done → blocks it and all younger entries.
  - Full ROB with all entries done → RSLOTS retired per cycle.
  - Wrap: head=RENTRIES-1 retiring 2 → indices 15,0; head → 1.
  - Excepting entry not yet done → waits; no exception.
  - redirect_ack_i in RUN or FLUSH is ignored.
  - Exception at slot 0 → 0 retires plus exc_o.

Test Plan:
- Reset mid-WAIT with rst pulsed asynchronously between edges → all outputs 0 immediately, state RUN, head=0.
- Head=0, entries 0..3 valid+done, no stall → cycle 1 commit_cnt=2, rid={0,1}, rob_clr=0x0003; cycle 2 rid={2,3}, clr=0x000C; head=4.
- Head=15, entries 15 and 0 valid+done → commit_v=2'b11, rid slot0=15, slot1=0, rob_clr=0x8001, head=1.
- Head=5, entry 5 done, entry 6 valid not done, stall toggled → cnt=0 while stalled; cnt=1 (rid 5) when unstalled; then head=6 and cnt stays 0 until done[6]=1.
- Exception path:
  - Head=8, entry 8 done, entry 9 done+exc → cnt=1 (rid 8), exc_o=1, exc_rid_o=9, head=9.
  - Next cycle flush_o=1, rob_clr=0xFFFF.
  - No retires until redirect_ack_i; first retire returns the cycle after the ack.
- Empty ROB (rob_v_i=0) for 10 cycles → commit_cnt=0, rob_clr=0, head constant throughout.

Source files
------------

// File: rtl/rob_commit_ctrl.sv
// In-order retire controller for the re-order buffer: retires up to RSLOTS
// completed entries per cycle from the head and runs the exception flush/redirect handshake.
module rob_commit_ctrl #(
  parameter int RENTRIES = 16,
  parameter int RSLOTS   = 2,
  parameter int RBW      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RENTRIES-1:0]   rob_v_i,
  input  logic [RENTRIES-1:0]   rob_done_i,
  input  logic [RENTRIES-1:0]   rob_exc_i,
  input  logic                  commit_stall_i,
  input  logic                  redirect_ack_i,
  output logic [RBW-1:0]        rob_head_o,
  output logic [RENTRIES-1:0]   rob_clr_o,
  output logic [RSLOTS-1:0]     commit_v_o,
  output logic [RSLOTS*RBW-1:0] commit_rid_o,
  output logic [2:0]            commit_cnt_o,
  output logic                  exc_o,
  output logic [RBW-1:0]        exc_rid_o,
  output logic                  flush_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [RBW:0] LIM = (RBW+1)'(RENTRIES);

  // Modulo-RENTRIES index add; offset never exceeds RSLOTS, so one wrap suffices.
  function automatic logic [RBW-1:0] wrap_add(input logic [RBW-1:0] base, input logic [2:0] off);
    logic [RBW:0] sum;
    sum = (RBW+1)'(base) + (RBW+1)'(off);
    if (sum >= LIM) begin
      wrap_add = RBW'(sum - LIM);
    end else begin
      wrap_add = RBW'(sum);
    end
  endfunction

  state_t                state_r, state_s;
  logic [RBW-1:0]        head_r, head_s;
  logic [RENTRIES-1:0]   clr_r, clr_s;
  logic [RSLOTS-1:0]     cv_r, cv_s;
  logic [RSLOTS*RBW-1:0] rid_r, rid_s;
  logic [2:0]            cnt_r, cnt_s;
  logic                  exc_r, exc_s;
  logic [RBW-1:0]        exc_rid_r, exc_rid_s;
  logic                  flush_r, flush_s;

  logic [RBW-1:0]        idx_s [RSLOTS];
  logic [RSLOTS-1:0]     ret_s;
  logic [RSLOTS-1:0]     hit_s;

  // Head-relative scan: a slot retires only if every older slot retired; hit marks the blocking excepting entry.
  always_comb begin
    logic prev_s;
    prev_s = 1'b1;
    ret_s  = '0;
    hit_s  = '0;
    for (int k = 0; k < RSLOTS; k++) begin
      idx_s[k] = wrap_add(head_r, 3'(k));
      ret_s[k] = prev_s & rob_v_i[idx_s[k]] & rob_done_i[idx_s[k]] & ~rob_exc_i[idx_s[k]];
      hit_s[k] = prev_s & rob_v_i[idx_s[k]] & rob_done_i[idx_s[k]] & rob_exc_i[idx_s[k]];
      prev_s   = ret_s[k];
    end
  end

  // Next-state and next-output logic; outputs default to idle pulses each cycle.
  always_comb begin
    state_s   = state_r;
    head_s    = head_r;
    clr_s     = '0;
    cv_s      = '0;
    rid_s     = '0;
    cnt_s     = 3'd0;
    exc_s     = 1'b0;
    exc_rid_s = exc_rid_r;
    flush_s   = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (!commit_stall_i) begin
          for (int k = 0; k < RSLOTS; k++) begin
            if (ret_s[k]) begin
              cv_s[k]              = 1'b1;
              rid_s[k*RBW +: RBW]  = idx_s[k];
              clr_s[idx_s[k]]      = 1'b1;
              cnt_s                = cnt_s + 3'd1;
              head_s               = wrap_add(head_r, 3'(k + 1));
            end else if (hit_s[k]) begin
              // Head already rests on the excepting entry; it stays allocated.
              exc_s     = 1'b1;
              exc_rid_s = idx_s[k];
              state_s   = ST_FLUSH;
            end else begin
              cnt_s = cnt_s;
            end
          end
        end else begin
          head_s = head_r;
        end
      end
      ST_FLUSH: begin
        flush_s = 1'b1;
        clr_s   = '1;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_ack_i) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_RUN;
      head_r    <= '0;
      clr_r     <= '0;
      cv_r      <= '0;
      rid_r     <= '0;
      cnt_r     <= 3'd0;
      exc_r     <= 1'b0;
      exc_rid_r <= '0;
      flush_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      head_r    <= head_s;
      clr_r     <= clr_s;
      cv_r      <= cv_s;
      rid_r     <= rid_s;
      cnt_r     <= cnt_s;
      exc_r     <= exc_s;
      exc_rid_r <= exc_rid_s;
      flush_r   <= flush_s;
    end
  end

  assign rob_head_o   = head_r;
  assign rob_clr_o    = clr_r;
  assign commit_v_o   = cv_r;
  assign commit_rid_o = rid_r;
  assign commit_cnt_o = cnt_r;
  assign exc_o        = exc_r;
  assign exc_rid_o    = exc_rid_r;
  assign flush_o      = flush_r;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: directed scenarios plus randomized
// traffic against a behavioural retire model.
module tb_rob_commit_ctrl;
  localparam int E = 16;
  localparam int S = 2;
  localparam int W = 4;
  localparam int P_RUN = 0, P_FLUSH_NEXT = 1, P_WAIT_ACK = 2;

  logic clk = 1'b0;
  logic rst;
  logic [E-1:0] rob_v_i, rob_done_i, rob_exc_i;
  logic commit_stall_i, redirect_ack_i;
  logic [W-1:0] rob_head_o, exc_rid_o;
  logic [E-1:0] rob_clr_o;
  logic [S-1:0] commit_v_o;
  logic [S*W-1:0] commit_rid_o;
  logic [2:0] commit_cnt_o;
  logic exc_o, flush_o;

  rob_commit_ctrl #(.RENTRIES(E), .RSLOTS(S), .RBW(W)) dut (
    .clk(clk), .rst(rst), .rob_v_i(rob_v_i), .rob_done_i(rob_done_i), .rob_exc_i(rob_exc_i),
    .commit_stall_i(commit_stall_i), .redirect_ack_i(redirect_ack_i), .rob_head_o(rob_head_o),
    .rob_clr_o(rob_clr_o), .commit_v_o(commit_v_o), .commit_rid_o(commit_rid_o),
    .commit_cnt_o(commit_cnt_o), .exc_o(exc_o), .exc_rid_o(exc_rid_o), .flush_o(flush_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_head, m_phase, m_exc_rid;
  logic [S-1:0] exp_v;
  logic [S*W-1:0] exp_rid;
  logic [E-1:0] exp_clr;
  int exp_cnt;
  logic exp_exc, exp_flush;

  // Behavioural model: predicts what the edge about to happen registers.
  task automatic model_step();
    int n, j;
    exp_v = '0; exp_rid = '0; exp_clr = '0; exp_cnt = 0; exp_exc = 1'b0; exp_flush = 1'b0;
    if (m_phase == P_RUN) begin
      if (!commit_stall_i) begin
        n = 0;
        while (n < S && rob_v_i[(m_head+n)%E] && rob_done_i[(m_head+n)%E] && !rob_exc_i[(m_head+n)%E]) n++;
        for (int k = 0; k < n; k++) begin
          exp_v[k] = 1'b1;
          exp_rid[k*W +: W] = W'((m_head+k)%E);
          exp_clr[(m_head+k)%E] = 1'b1;
        end
        exp_cnt = n;
        j = (m_head + n) % E;
        if (n < S && rob_v_i[j] && rob_done_i[j] && rob_exc_i[j]) begin
          exp_exc = 1'b1; m_exc_rid = j; m_phase = P_FLUSH_NEXT;
        end
        m_head = j;
      end
    end else if (m_phase == P_FLUSH_NEXT) begin
      exp_flush = 1'b1; exp_clr = '1; m_phase = P_WAIT_ACK;
    end else if (redirect_ack_i) begin
      m_phase = P_RUN;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rob_v_i = '0; rob_done_i = '0; rob_exc_i = '0; commit_stall_i = 1'b0; redirect_ack_i = 1'b0;
  endtask

  // Walk the head to target by retiring one or two entries per cycle.
  task automatic seek(input int target);
    int guard = 0;
    while (m_head != target && guard < 40) begin
      clear_inputs();
      rob_v_i[m_head] = 1'b1; rob_done_i[m_head] = 1'b1;
      if ((target - m_head + E) % E >= 2) begin
        rob_v_i[(m_head+1)%E] = 1'b1; rob_done_i[(m_head+1)%E] = 1'b1;
      end
      tick();
      guard++;
    end
    checks++;
    if (rob_head_o !== W'(target)) begin
      errors++; $display("FAIL seek_head got %0d want %0d", rob_head_o, target);
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_inputs();
    #12;
    checks++;
    if ({rob_head_o, rob_clr_o, commit_v_o, commit_rid_o, commit_cnt_o, exc_o, exc_rid_o, flush_o} !== '0) begin
      errors++; $display("FAIL reset_outputs got head=%0d clr=%h cnt=%0d", rob_head_o, rob_clr_o, commit_cnt_o);
    end
    @(negedge clk); rst = 1'b0;
    m_head = 0; m_phase = P_RUN; m_exc_rid = 0;
    tick();
  endtask

  task automatic test_in_order();
    clear_inputs(); rob_v_i[3:0] = 4'hF; rob_done_i[3:0] = 4'hF;
    tick();
    checks++;
    if (commit_cnt_o !== 3'd2 || commit_rid_o !== 8'h10 || rob_clr_o !== 16'h0003 || rob_head_o !== 4'd2) begin
      errors++; $display("FAIL in_order_1 got cnt=%0d rid=%h clr=%h head=%0d want 2 10 0003 2", commit_cnt_o, commit_rid_o, rob_clr_o, rob_head_o);
    end
    rob_v_i[1:0] = 2'b00;
    tick();
    checks++;
    if (commit_cnt_o !== 3'd2 || commit_rid_o !== 8'h32 || rob_clr_o !== 16'h000C || rob_head_o !== 4'd4) begin
      errors++; $display("FAIL in_order_2 got cnt=%0d rid=%h clr=%h head=%0d want 2 32 000c 4", commit_cnt_o, commit_rid_o, rob_clr_o, rob_head_o);
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    seek(5);
    rob_v_i[7:5] = 3'b111; rob_done_i[5] = 1'b1; rob_exc_i[7] = 1'b1; commit_stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (commit_cnt_o !== 3'd0 || commit_v_o !== 2'b00 || rob_head_o !== 4'd5) begin
        errors++; $display("FAIL stall_hold got cnt=%0d v=%b head=%0d want 0 00 5", commit_cnt_o, commit_v_o, rob_head_o);
      end
    end
    commit_stall_i = 1'b0;
    tick();
    checks++;
    if (commit_cnt_o !== 3'd1 || commit_v_o !== 2'b01 || commit_rid_o[3:0] !== 4'd5 || rob_clr_o !== 16'h0020 || rob_head_o !== 4'd6) begin
      errors++; $display("FAIL stall_release got cnt=%0d rid0=%0d clr=%h head=%0d want 1 5 0020 6", commit_cnt_o, commit_rid_o[3:0], rob_clr_o, rob_head_o);
    end
    rob_v_i[5] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (commit_cnt_o !== 3'd0 || rob_head_o !== 4'd6 || exc_o !== 1'b0) begin
        errors++; $display("FAIL not_done_block got cnt=%0d head=%0d exc=%b want 0 6 0", commit_cnt_o, rob_head_o, exc_o);
      end
    end
    rob_done_i[6] = 1'b1;
    tick();
    checks++;
    if (commit_cnt_o !== 3'd1 || commit_rid_o[3:0] !== 4'd6 || rob_head_o !== 4'd7 || exc_o !== 1'b0) begin
      errors++; $display("FAIL exc_not_done got cnt=%0d rid0=%0d head=%0d exc=%b want 1 6 7 0", commit_cnt_o, commit_rid_o[3:0], rob_head_o, exc_o);
    end
    clear_inputs();
  endtask

  task automatic test_exception();
    seek(8);
    rob_v_i[9:8] = 2'b11; rob_done_i[9:8] = 2'b11; rob_exc_i[9] = 1'b1;
    tick();
    checks++;
    if (commit_cnt_o !== 3'd1 || commit_v_o !== 2'b01 || commit_rid_o[3:0] !== 4'd8 || exc_o !== 1'b1 || exc_rid_o !== 4'd9 || rob_head_o !== 4'd9 || flush_o !== 1'b0) begin
      errors++; $display("FAIL exc_detect got cnt=%0d rid0=%0d exc=%b erid=%0d head=%0d", commit_cnt_o, commit_rid_o[3:0], exc_o, exc_rid_o, rob_head_o);
    end
    rob_v_i[8] = 1'b0; redirect_ack_i = 1'b1;
    tick();
    checks++;
    if (flush_o !== 1'b1 || rob_clr_o !== 16'hFFFF || commit_v_o !== 2'b00 || exc_o !== 1'b0 || rob_head_o !== 4'd9) begin
      errors++; $display("FAIL exc_flush got flush=%b clr=%h v=%b exc=%b head=%0d", flush_o, rob_clr_o, commit_v_o, exc_o, rob_head_o);
    end
    redirect_ack_i = 1'b0; rob_v_i = '1; rob_done_i = '1; rob_exc_i = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) redirect_ack_i = 1'b1;
      tick();
      checks++;
      if (commit_cnt_o !== 3'd0 || flush_o !== 1'b0 || rob_clr_o !== 16'h0000 || exc_o !== 1'b0 || rob_head_o !== 4'd9) begin
        errors++; $display("FAIL exc_wait cyc=%0d got cnt=%0d flush=%b clr=%h head=%0d", i, commit_cnt_o, flush_o, rob_clr_o, rob_head_o);
      end
    end
    redirect_ack_i = 1'b0;
    tick();
    checks++;
    if (commit_cnt_o !== 3'd2 || commit_rid_o !== 8'hA9 || rob_head_o !== 4'd11 || exc_rid_o !== 4'd9) begin
      errors++; $display("FAIL exc_resume got cnt=%0d rid=%h head=%0d erid=%0d want 2 a9 11 9", commit_cnt_o, commit_rid_o, rob_head_o, exc_rid_o);
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    seek(15);
    rob_v_i[15] = 1'b1; rob_done_i[15] = 1'b1; rob_v_i[0] = 1'b1; rob_done_i[0] = 1'b1;
    tick();
    checks++;
    if (commit_v_o !== 2'b11 || commit_rid_o[3:0] !== 4'd15 || commit_rid_o[7:4] !== 4'd0 || rob_clr_o !== 16'h8001 || rob_head_o !== 4'd1) begin
      errors++; $display("FAIL wrap got v=%b rid=%h clr=%h head=%0d want 11 0f 8001 1", commit_v_o, commit_rid_o, rob_clr_o, rob_head_o);
    end
    clear_inputs();
  endtask

  task automatic test_empty();
    int h0;
    clear_inputs();
    rob_done_i = '1;
    h0 = m_head;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (commit_cnt_o !== 3'd0 || rob_clr_o !== 16'h0000 || rob_head_o !== W'(h0)) begin
        errors++; $display("FAIL empty cyc=%0d got cnt=%0d clr=%h head=%0d want 0 0000 %0d", i, commit_cnt_o, rob_clr_o, rob_head_o, h0);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    int h;
    h = m_head;
    rob_v_i[h] = 1'b1; rob_done_i[h] = 1'b1; rob_exc_i[h] = 1'b1;
    tick();
    checks++;
    if (exc_o !== 1'b1 || commit_cnt_o !== 3'd0 || commit_v_o !== 2'b00 || rob_head_o !== W'(h) || exc_rid_o !== W'(h)) begin
      errors++; $display("FAIL exc_slot0 got exc=%b cnt=%0d head=%0d erid=%0d want 1 0 %0d %0d", exc_o, commit_cnt_o, rob_head_o, exc_rid_o, h, h);
    end
    clear_inputs();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rob_head_o, rob_clr_o, commit_v_o, commit_rid_o, commit_cnt_o, exc_o, exc_rid_o, flush_o} !== '0) begin
      errors++; $display("FAIL async_reset got head=%0d erid=%0d flush=%b", rob_head_o, exc_rid_o, flush_o);
    end
    #1 rst = 1'b0;
    m_head = 0; m_phase = P_RUN; m_exc_rid = 0;
    rob_v_i[1:0] = 2'b11; rob_done_i[1:0] = 2'b11;
    tick();
    checks++;
    if (commit_cnt_o !== 3'd2 || rob_head_o !== 4'd2) begin
      errors++; $display("FAIL reset_to_run got cnt=%0d head=%0d want 2 2", commit_cnt_o, rob_head_o);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rob_v_i        = E'($urandom | $urandom);
      rob_done_i     = E'($urandom | $urandom);
      rob_exc_i      = E'($urandom & $urandom & $urandom);
      commit_stall_i = ($urandom_range(0, 4) == 0);
      redirect_ack_i = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (commit_v_o !== exp_v || commit_cnt_o !== 3'(exp_cnt) || rob_clr_o !== exp_clr || exc_o !== exp_exc ||
          flush_o !== exp_flush || rob_head_o !== W'(m_head) || exc_rid_o !== W'(m_exc_rid)) begin
        errors++;
        $display("FAIL random cyc=%0d got v=%b cnt=%0d clr=%h exc=%b flush=%b head=%0d erid=%0d want %b %0d %h %b %b %0d %0d",
                 i, commit_v_o, commit_cnt_o, rob_clr_o, exc_o, flush_o, rob_head_o, exc_rid_o,
                 exp_v, exp_cnt, exp_clr, exp_exc, exp_flush, m_head, m_exc_rid);
      end
      for (int k = 0; k < S; k++) begin
        if (exp_v[k]) begin
          checks++;
          if (commit_rid_o[k*W +: W] !== exp_rid[k*W +: W]) begin
            errors++; $display("FAIL random_rid cyc=%0d slot=%0d got %0d want %0d", i, k, commit_rid_o[k*W +: W], exp_rid[k*W +: W]);
          end
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_stall();
    test_exception();
    test_wrap();
    test_empty();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
